// File: rtl/uart_telemetry_pkg.sv
// uart_telemetry_pkg: shared constants, state encoding and frame helpers for the telemetry framer.
package uart_telemetry_pkg;

    localparam logic [7:0] HEADER_DEF = 8'hAA;
    localparam int FRAME_LEN = 7;

    localparam int FLAG_TIME_ALARM = 0;
    localparam int FLAG_TEMP_ALARM = 1;
    localparam int FLAG_ABORTED    = 2;
    localparam int FLAG_SEQ        = 4;

    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_HI, WAIT_LO, DONE} state_t;

    typedef struct packed {
        logic [7:0] hour;
        logic [7:0] minute;
        logic [7:0] second;
        logic [7:0] temp_c;
        logic [7:0] flags;
    } snap_t;

    function automatic logic [7:0] make_flags(input logic [3:0] seq, input logic aborted,
                                              input logic temp_alarm, input logic time_alarm);
        logic [7:0] f;
        f = '0;
        f[FLAG_SEQ +: 4]    = seq;
        f[FLAG_ABORTED]     = aborted;
        f[FLAG_TEMP_ALARM]  = temp_alarm;
        f[FLAG_TIME_ALARM]  = time_alarm;
        return f;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input snap_t s,
                                              input logic [7:0] header);
        logic [7:0] csum;
        csum = s.hour + s.minute + s.second + s.temp_c + s.flags;
        return idx == 3'd0 ? header   :
               idx == 3'd1 ? s.hour   :
               idx == 3'd2 ? s.minute :
               idx == 3'd3 ? s.second :
               idx == 3'd4 ? s.temp_c :
               idx == 3'd5 ? s.flags  : csum;
    endfunction

endpackage

// File: rtl/uart_telemetry_framer_byte_hs.sv
// uart_byte_hs: one-byte uart_en/uart_tx_busy handshake with a busy-rise timeout.
module uart_byte_hs
    import uart_telemetry_pkg::*;
#(
    parameter int TIMEOUT = 32
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start,
    input  logic [7:0] byte_in,
    input  logic       uart_tx_busy,
    output logic       uart_en,
    output logic [7:0] uart_din,
    output logic       done,
    output logic       timeout
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    state_t        state;
    logic [CW-1:0] cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            uart_en  <= 1'b0;
            uart_din <= '0;
            done     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            uart_en <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state    <= SEND;
                    uart_en  <= 1'b1;
                    uart_din <= byte_in;
                    cnt      <= '0;
                end
                SEND: state <= WAIT_HI;
                WAIT_HI: begin
                    if (uart_tx_busy) state <= WAIT_LO;
                    else if (cnt == CW'(TIMEOUT - 1)) begin
                        state   <= IDLE;
                        timeout <= 1'b1;
                    end else cnt <= cnt + 1'b1;
                end
                WAIT_LO: if (!uart_tx_busy) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_telemetry_framer.sv
// uart_telemetry_framer: snapshots time/temperature/alarm state on each trigger and sends it as a 7-byte frame.
module uart_telemetry_framer
    import uart_telemetry_pkg::*;
#(
    parameter logic [7:0] HEADER       = HEADER_DEF,
    parameter int         BUSY_TIMEOUT = 32
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       tick_1s,
    input  logic       alarm_evt,
    input  logic [7:0] hour,
    input  logic [7:0] minute,
    input  logic [7:0] second,
    input  logic [7:0] temp_c,
    input  logic       time_alarm,
    input  logic       temp_alarm,
    input  logic       uart_tx_busy,
    output logic       uart_en,
    output logic [7:0] uart_din,
    output logic       frame_busy,
    output logic [7:0] drop_cnt,
    output logic       tx_err
);

    state_t     state;
    snap_t      snap;
    logic [2:0] idx;
    logic [3:0] seq;
    logic       pending;
    logic       aborted;
    logic       trig;
    logic       start;
    logic       done;
    logic       timeout;
    logic       last;
    logic [7:0] byte_in;

    assign trig    = tick_1s | alarm_evt;
    assign last    = idx == 3'(FRAME_LEN - 1);
    // The header goes out during LOAD, before the snapshot registers are valid.
    assign start   = state == LOAD || (state == SEND && done && !last);
    assign byte_in = state == LOAD ? HEADER : frame_byte(idx + 3'd1, snap, HEADER);

    uart_byte_hs #(.TIMEOUT(BUSY_TIMEOUT)) u_hs (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .start        (start),
        .byte_in      (byte_in),
        .uart_tx_busy (uart_tx_busy),
        .uart_en      (uart_en),
        .uart_din     (uart_din),
        .done         (done),
        .timeout      (timeout)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            snap       <= '0;
            idx        <= '0;
            seq        <= '0;
            pending    <= 1'b0;
            aborted    <= 1'b0;
            frame_busy <= 1'b0;
            drop_cnt   <= '0;
            tx_err     <= 1'b0;
        end else begin
            // IDLE and DONE consume a queued trigger; elsewhere a second one is dropped.
            pending <= state == IDLE ? pending & trig : state == DONE ? trig : pending | trig;
            if (trig && pending && state != IDLE && state != DONE && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
            case (state)
                IDLE: if (trig || pending) state <= LOAD;
                LOAD: begin
                    snap       <= {hour, minute, second, temp_c,
                                   make_flags(seq, aborted, temp_alarm, time_alarm)};
                    aborted    <= 1'b0;
                    idx        <= '0;
                    frame_busy <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    if (timeout) begin
                        tx_err     <= 1'b1;
                        aborted    <= 1'b1;
                        seq        <= seq + 4'd1;
                        frame_busy <= 1'b0;
                        state      <= IDLE;
                    end else if (done) begin
                        if (last) state <= DONE;
                        else idx <= idx + 3'd1;
                    end
                end
                DONE: begin
                    frame_busy <= 1'b0;
                    seq        <= seq + 4'd1;
                    state      <= pending ? LOAD : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_telemetry_framer.sv
// tb_uart_telemetry_framer: directed vectors against a uart_send busy model for the telemetry framer.
module tb_uart_telemetry_framer;

    typedef struct {
        logic [7:0]  h, m, s, t;
        logic        tm, ta;
        logic [55:0] exp;
    } vec_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        tick_1s = 1'b0;
    logic        alarm_evt = 1'b0;
    logic [7:0]  hour = '0, minute = '0, second = '0, temp_c = '0;
    logic        time_alarm = 1'b0, temp_alarm = 1'b0;
    logic        uart_tx_busy = 1'b0;
    logic        uart_en, frame_busy, tx_err;
    logic [7:0]  uart_din, drop_cnt;

    int          checks = 0, failures = 0;
    int          cyc = 0, trig_cyc = 0;
    int          busy_len = 1042, hold = 0, hold_at = -1, en_n = 0;
    logic        no_rise = 1'b0, arm = 1'b0;
    logic [7:0]  got[$];
    int          en_cyc[$];
    vec_t        vecs[4];

    always #5 sys_clk = ~sys_clk;

    uart_telemetry_framer dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .tick_1s      (tick_1s),
        .alarm_evt    (alarm_evt),
        .hour         (hour),
        .minute       (minute),
        .second       (second),
        .temp_c       (temp_c),
        .time_alarm   (time_alarm),
        .temp_alarm   (temp_alarm),
        .uart_tx_busy (uart_tx_busy),
        .uart_en      (uart_en),
        .uart_din     (uart_din),
        .frame_busy   (frame_busy),
        .drop_cnt     (drop_cnt),
        .tx_err       (tx_err)
    );

    // Monitor: logs every strobe and flags any strobe issued inside a busy window.
    always @(posedge sys_clk) begin
        cyc++;
        if (tick_1s | alarm_evt) trig_cyc = cyc;
        if (uart_en) begin
            checks++;
            if (arm || uart_tx_busy) begin
                failures++;
                $display("FAIL en_during_busy cyc=%0d busy=%b armed=%b required no strobe", cyc, uart_tx_busy, arm);
            end
            got.push_back(uart_din);
            en_cyc.push_back(cyc);
        end
    end

    // uart_send model: busy rises two cycles after the strobe and stays up busy_len cycles.
    always @(posedge sys_clk) begin
        if (uart_en) en_n <= en_n + 1;
        arm <= uart_en && !no_rise;
        if (arm) begin
            uart_tx_busy <= 1'b1;
            hold <= (en_n - 1 == hold_at) ? 5000 : busy_len;
        end else if (uart_tx_busy) begin
            if (hold <= 1) uart_tx_busy <= 1'b0;
            else hold <= hold - 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input vec_t v);
        hour = v.h; minute = v.m; second = v.s; temp_c = v.t;
        time_alarm = v.tm; temp_alarm = v.ta;
    endtask

    task automatic trigger(input logic t, input logic a);
        @(negedge sys_clk);
        tick_1s = t; alarm_evt = a;
        @(negedge sys_clk);
        tick_1s = 1'b0; alarm_evt = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int limit);
        int k = 0;
        while (got.size() < n && k < limit) begin
            @(negedge sys_clk);
            k++;
        end
        check("byte_count", 32'(got.size()), 32'(n));
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        while ((frame_busy || uart_tx_busy) && k < limit) begin
            @(negedge sys_clk);
            k++;
        end
        check("frame_idle", 32'(frame_busy), 32'd0);
    endtask

    task automatic check_frame(input string name, input int base, input logic [55:0] exp);
        for (int i = 0; i < 7; i++)
            check($sformatf("%s_b%0d", name, i),
                  32'(base + i < got.size() ? got[base + i] : 8'hXX), 32'(exp[8*(6-i) +: 8]));
    endtask

    initial begin
        int base;
        int k;
        vecs[0] = '{8'd12, 8'd34, 8'd56, 8'd28,  1'b0, 1'b1, 56'hAA0C22381C0284};
        vecs[1] = '{8'd23, 8'd59, 8'd59, 8'd100, 1'b1, 1'b1, 56'hAA173B3B641304};
        vecs[2] = '{8'd0,  8'd0,  8'd0,  8'd0,   1'b0, 1'b0, 56'hAA000000002020};
        vecs[3] = '{8'd7,  8'd5,  8'd9,  8'd127, 1'b1, 1'b0, 56'hAA0705097F31C5};

        repeat (3) @(negedge sys_clk);
        check("rst_uart_en", 32'(uart_en), 0);
        check("rst_uart_din", 32'(uart_din), 0);
        check("rst_frame_busy", 32'(frame_busy), 0);
        check("rst_drop_cnt", 32'(drop_cnt), 0);
        check("rst_tx_err", 32'(tx_err), 0);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // Table: seq 0..3, alternating trigger source.
        for (int i = 0; i < 4; i++) begin
            set_in(vecs[i]);
            base = got.size();
            trigger(!i[0], i[0]);
            if (i == 0) begin
                @(negedge sys_clk);
                hour = 8'h55; minute = 8'h55; second = 8'h55; temp_c = 8'h55; temp_alarm = 1'b0;
                wait_bytes(base + 1, 20);
                check("latency", 32'(en_cyc[base] - trig_cyc), 32'd2);
            end
            wait_bytes(base + 7, 9000);
            check("busy_at_last_byte", 32'(frame_busy), 32'd1);
            wait_idle(2000);
            check_frame($sformatf("vec%0d", i), base, vecs[i].exp);
        end
        check("table_drop_cnt", 32'(drop_cnt), 0);

        // Busy held 5000 cycles on byte 3; seq 4.
        set_in(vecs[0]);
        base = got.size();
        hold_at = base + 2;
        trigger(1'b1, 1'b0);
        wait_bytes(base + 7, 16000);
        wait_idle(2000);
        check_frame("hold", base, 56'hAA0C22381C42C4);
        if (got.size() >= base + 4)
            check("hold_gap", 32'(en_cyc[base + 3] - en_cyc[base + 2] > 5000), 32'd1);
        hold_at = -1;
        busy_len = 100;

        // Overrun: start + alarm + simultaneous pair during frame seq 5 -> one queued frame, one drop.
        base = got.size();
        trigger(1'b1, 1'b0);
        wait_bytes(base + 2, 1000);
        trigger(1'b0, 1'b1);
        trigger(1'b1, 1'b1);
        wait_bytes(base + 14, 3000);
        wait_idle(1000);
        check("overrun_drop_cnt", 32'(drop_cnt), 32'd1);
        check_frame("overrun_f1", base, 56'hAA0C22381C52D4);
        check_frame("overrun_f2", base + 7, 56'hAA0C22381C62E4);
        if (got.size() >= base + 8)
            check("overrun_back2back", 32'(en_cyc[base + 7] - en_cyc[base + 6] <= 115), 32'd1);

        // Timeout on seq 7: busy never rises.
        no_rise = 1'b1;
        base = got.size();
        trigger(1'b1, 1'b0);
        wait_bytes(base + 1, 20);
        repeat (20) @(negedge sys_clk);
        check("timeout_early", 32'(tx_err), 0);
        repeat (20) @(negedge sys_clk);
        check("timeout_tx_err", 32'(tx_err), 32'd1);
        check("timeout_frame_busy", 32'(frame_busy), 0);
        check("timeout_drop_cnt", 32'(drop_cnt), 32'd1);
        check("timeout_no_more_bytes", 32'(got.size()), 32'(base + 1));
        no_rise = 1'b0;

        base = got.size();
        trigger(1'b0, 1'b1);
        wait_bytes(base + 7, 1500);
        wait_idle(1000);
        check_frame("after_abort", base, 56'hAA0C22381C8608);
        base = got.size();
        trigger(1'b1, 1'b0);
        wait_bytes(base + 7, 1500);
        wait_idle(1000);
        check_frame("after_after_abort", base, 56'hAA0C22381C9214);
        check("tx_err_sticky", 32'(tx_err), 32'd1);

        // Reset asserted while byte 4 is being strobed.
        base = got.size();
        trigger(1'b1, 1'b0);
        wait_bytes(base + 3, 1500);
        k = 0;
        while (!uart_en && k < 1000) begin
            @(posedge sys_clk);
            #1;
            k++;
        end
        check("rst_mid_saw_en", 32'(uart_en), 32'd1);
        #1 sys_rst_n = 1'b0;
        #1;
        check("rst_mid_uart_en", 32'(uart_en), 0);
        check("rst_mid_frame_busy", 32'(frame_busy), 0);
        check("rst_mid_drop_cnt", 32'(drop_cnt), 0);
        check("rst_mid_tx_err", 32'(tx_err), 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        k = 0;
        while (uart_tx_busy && k < 2000) begin
            @(negedge sys_clk);
            k++;
        end
        base = got.size();
        trigger(1'b1, 1'b0);
        wait_bytes(base + 7, 1500);
        wait_idle(1000);
        check_frame("post_reset", base, 56'hAA0C22381C0284);

        // Both triggers together in IDLE -> one frame, seq 1.
        base = got.size();
        trigger(1'b1, 1'b1);
        wait_bytes(base + 7, 1500);
        wait_idle(1000);
        repeat (300) @(negedge sys_clk);
        check("simul_one_frame", 32'(got.size()), 32'(base + 7));
        check("simul_drop_cnt", 32'(drop_cnt), 0);
        check_frame("simul", base, 56'hAA0C22381C1294);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
